// File: rtl/i2s_pkg.sv
// Shared I2S constants and sample types, common to the transmitter and receiver.
// No logic or latency here; slot_bit gives the serial bit for a slot position.
package i2s_pkg;

    localparam int SAMPLE_BITS = 16;
    localparam int SLOT_BITS   = 32;
    localparam int FRAME_BITS  = 64;

    typedef struct packed {
        logic signed [SAMPLE_BITS-1:0] left;
        logic signed [SAMPLE_BITS-1:0] right;
    } stereo_sample_t;

    // Positions 1..16 carry word[16-pos] (MSB first, one bit after the LRCLK edge); all others are 0.
    function automatic logic slot_bit(input logic [SAMPLE_BITS-1:0] word, input logic [4:0] pos);
        logic [4:0] q;
        q        = pos - 5'd1;
        slot_bit = q[4] ? 1'b0 : word[4'd15 - q[3:0]];
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK divider: toggles bclk every HALF_DIV cycles; rise/fall strobes are high in the cycle
// whose clock edge changes bclk. Free-running, no backpressure.
module i2s_bclk_gen #(
    parameter int HALF_DIV = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic bclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic             tc;

    assign tc = (div_q == DIV_LAST);

    always_comb begin
        div_d  = tc ? '0 : div_q + 1'b1;
        bclk_d = bclk_q ^ tc;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk_o = bclk_q;
    assign rise_o = tc & ~bclk_q;
    assign fall_o = tc &  bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// Philips-I2S master transmitter: one-pair holding register feeding a 64-bit frame serializer.
// A pair leaves holding at the next frame start; ready is low while holding is full.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int HALF_DIV = 32
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic signed [SAMPLE_BITS-1:0] left_in,
    input  logic signed [SAMPLE_BITS-1:0] right_in,
    input  logic                          sample_valid_in,
    output logic                          sample_ready_out,
    output logic                          bclk_out,
    output logic                          lrclk_out,
    output logic                          sdata_out,
    output logic                          frame_start_out,
    output logic                          underrun_out
);

    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

    logic           bclk, bclk_rise, bclk_fall;
    logic [5:0]     bit_cnt_q, bit_cnt_d;
    logic           lrclk_q, lrclk_d;
    logic           sdata_q, sdata_d;
    logic           fs_q, fs_d;
    logic           und_q, und_d;
    logic           hold_empty_q, hold_empty_d;
    stereo_sample_t hold_q, hold_d;
    stereo_sample_t frame_q, frame_d;
    logic           accept, load;

    i2s_bclk_gen #(
        .HALF_DIV(HALF_DIV)
    ) u_bclk_gen (
        .clk_i (clk_in),
        .rst_i (rst_in),
        .bclk_o(bclk),
        .rise_o(bclk_rise),
        .fall_o(bclk_fall)
    );

    assign accept = sample_valid_in & hold_empty_q;
    // The falling edge that wraps bit_cnt to 0 opens a new frame.
    assign load   = bclk_fall & (bit_cnt_q == LAST_BIT);

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        lrclk_d      = lrclk_q;
        sdata_d      = sdata_q;
        fs_d         = 1'b0;
        und_d        = 1'b0;
        hold_d       = hold_q;
        hold_empty_d = hold_empty_q;
        frame_d      = frame_q;

        if (bclk_fall) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            lrclk_d   = bit_cnt_d[5];
            sdata_d   = slot_bit(bit_cnt_d[5] ? frame_q.right : frame_q.left, bit_cnt_d[4:0]);
        end

        if (load) begin
            fs_d = 1'b1;
            if (hold_empty_q) begin
                frame_d = '0;
                und_d   = 1'b1;
            end else begin
                frame_d      = hold_q;
                hold_empty_d = 1'b1;
            end
        end

        // Only possible while holding is empty, so never overlaps a consuming load.
        if (accept) begin
            hold_d.left  = left_in;
            hold_d.right = right_in;
            hold_empty_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bit_cnt_q    <= LAST_BIT;
            lrclk_q      <= 1'b1;
            sdata_q      <= 1'b0;
            fs_q         <= 1'b0;
            und_q        <= 1'b0;
            hold_q       <= '0;
            hold_empty_q <= 1'b1;
            frame_q      <= '0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            lrclk_q      <= lrclk_d;
            sdata_q      <= sdata_d;
            fs_q         <= fs_d;
            und_q        <= und_d;
            hold_q       <= hold_d;
            hold_empty_q <= hold_empty_d;
            frame_q      <= frame_d;
        end
    end

    strobes_exclusive: assert property (@(posedge clk_in) disable iff (rst_in) !(bclk_rise && bclk_fall));

    assign sample_ready_out = hold_empty_q;
    assign bclk_out         = bclk;
    assign lrclk_out        = lrclk_q;
    assign sdata_out        = sdata_q;
    assign frame_start_out  = fs_q;
    assign underrun_out     = und_q;

endmodule
